// File: rtl/circle_plotter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | circle_plotter                                                             |
// | Optional frame clear followed by a clipped midpoint-circle outline, driven |
// | onto a vga_adapter write port.                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module circle_plotter #(
   parameter int         SCREEN_W  = 160,
   parameter int         SCREEN_H  = 120,
   parameter bit         CLEAR_EN  = 1'b1,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] centre_x,
   input  logic [6:0] centre_y,
   input  logic [6:0] radius,
   input  logic [2:0] colour_in,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   // Octant states are consecutive so each one advances by a simple increment.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CLEAR  = 4'd1,
      S_INIT   = 4'd2,
      S_OCT0   = 4'd3,
      S_OCT1   = 4'd4,
      S_OCT2   = 4'd5,
      S_OCT3   = 4'd6,
      S_OCT4   = 4'd7,
      S_OCT5   = 4'd8,
      S_OCT6   = 4'd9,
      S_OCT7   = 4'd10,
      S_UPDATE = 4'd11,
      S_DONE   = 4'd12
   } state_t;

   localparam logic        [7:0] c_x_last = 8'(SCREEN_W - 1);
   localparam logic        [6:0] c_y_last = 7'(SCREEN_H - 1);
   localparam logic signed [9:0] c_w_lim  = 10'(SCREEN_W);
   localparam logic signed [9:0] c_h_lim  = 10'(SCREEN_H);

   state_t             r_state;
   logic         [7:0] r_cx;
   logic         [6:0] r_cy;
   logic         [6:0] r_rad;
   logic         [2:0] r_col;
   logic signed  [9:0] r_ox;
   logic signed  [9:0] r_oy;
   logic signed  [9:0] r_crit;
   logic         [7:0] r_clr_x;
   logic         [6:0] r_clr_y;

   logic signed  [9:0] w_cx;
   logic signed  [9:0] w_cy;
   logic signed  [9:0] w_sx;
   logic signed  [9:0] w_sy;
   logic               w_on_screen;
   logic               w_crit_le0;
   logic signed  [9:0] w_oy_next;
   logic signed  [9:0] w_ox_next;
   logic signed  [9:0] w_step;
   logic signed  [9:0] w_crit_next;

   assign w_cx = signed'({2'b00, r_cx});
   assign w_cy = signed'({3'b000, r_cy});

   always_comb begin
      w_sx = w_cx;
      w_sy = w_cy;
      case (r_state)
         S_OCT0:  begin w_sx = w_cx + r_ox; w_sy = w_cy + r_oy; end
         S_OCT1:  begin w_sx = w_cx + r_oy; w_sy = w_cy + r_ox; end
         S_OCT2:  begin w_sx = w_cx - r_ox; w_sy = w_cy + r_oy; end
         S_OCT3:  begin w_sx = w_cx - r_oy; w_sy = w_cy + r_ox; end
         S_OCT4:  begin w_sx = w_cx - r_ox; w_sy = w_cy - r_oy; end
         S_OCT5:  begin w_sx = w_cx - r_oy; w_sy = w_cy - r_ox; end
         S_OCT6:  begin w_sx = w_cx + r_ox; w_sy = w_cy - r_oy; end
         S_OCT7:  begin w_sx = w_cx + r_oy; w_sy = w_cy - r_ox; end
         default: begin w_sx = w_cx;        w_sy = w_cy;        end
      endcase
   end

   // Negative sums are rejected outright, so nothing wraps back onto the screen.
   assign w_on_screen = !w_sx[9] && (w_sx < c_w_lim) && !w_sy[9] && (w_sy < c_h_lim);

   assign w_crit_le0  = (r_crit <= 10'sd0);
   assign w_oy_next   = r_oy + 10'sd1;
   assign w_ox_next   = w_crit_le0 ? r_ox : (r_ox - 10'sd1);
   assign w_step      = w_crit_le0 ? w_oy_next : (w_oy_next - w_ox_next);
   assign w_crit_next = r_crit + (w_step <<< 1) + 10'sd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cx    <= '0;
         r_cy    <= '0;
         r_rad   <= '0;
         r_col   <= '0;
         r_ox    <= '0;
         r_oy    <= '0;
         r_crit  <= '0;
         r_clr_x <= '0;
         r_clr_y <= '0;
         x       <= '0;
         y       <= '0;
         colour  <= '0;
         plot    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         plot <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cx    <= centre_x;
                  r_cy    <= centre_y;
                  r_rad   <= radius;
                  r_col   <= colour_in;
                  r_clr_x <= '0;
                  r_clr_y <= '0;
                  busy    <= 1'b1;
                  r_state <= CLEAR_EN ? S_CLEAR : S_INIT;
               end
            end
            S_CLEAR: begin
               x      <= r_clr_x;
               y      <= r_clr_y;
               colour <= BG_COLOUR;
               plot   <= 1'b1;
               if (r_clr_x == c_x_last) begin
                  r_clr_x <= '0;
                  if (r_clr_y == c_y_last) begin
                     r_clr_y <= '0;
                     r_state <= S_INIT;
                  end else begin
                     r_clr_y <= r_clr_y + 7'd1;
                  end
               end else begin
                  r_clr_x <= r_clr_x + 8'd1;
               end
            end
            S_INIT: begin
               r_ox    <= signed'({3'b000, r_rad});
               r_oy    <= '0;
               r_crit  <= 10'sd1 - signed'({3'b000, r_rad});
               r_state <= S_OCT0;
            end
            S_OCT0, S_OCT1, S_OCT2, S_OCT3, S_OCT4, S_OCT5, S_OCT6, S_OCT7: begin
               if (w_on_screen) begin
                  x      <= w_sx[7:0];
                  y      <= w_sy[6:0];
                  colour <= r_col;
                  plot   <= 1'b1;
               end
               r_state <= state_t'(r_state + 4'd1);
            end
            S_UPDATE: begin
               r_oy   <= w_oy_next;
               r_ox   <= w_ox_next;
               r_crit <= w_crit_next;
               if (w_oy_next <= w_ox_next) begin
                  r_state <= S_OCT0;
               end else begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               // Waiting for start to fall prevents a held start from retriggering.
               if (!start) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_circle_plotter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_circle_plotter                                                          |
// | Self-checking bench: directed and random circles against a midpoint model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_circle_plotter;

   logic       clock = 1'b0;
   logic       reset;
   logic       start0;
   logic       start1;
   logic [7:0] centre_x;
   logic [6:0] centre_y;
   logic [6:0] radius;
   logic [2:0] colour_in;
   logic [7:0] x0, x1;
   logic [6:0] y0, y1;
   logic [2:0] c0, c1;
   logic       plot0, plot1, busy0, busy1, done0, done1;

   int tests  = 0;
   int failed = 0;
   int exp_q[$];
   int got_q[$];

   always #5 clock = ~clock;

   circle_plotter #(.SCREEN_W(160), .SCREEN_H(120), .CLEAR_EN(1'b0), .BG_COLOUR(3'b000)) u_dut0 (
      .clock(clock), .reset(reset), .start(start0),
      .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour_in(colour_in),
      .x(x0), .y(y0), .colour(c0), .plot(plot0), .busy(busy0), .done(done0));

   circle_plotter #(.SCREEN_W(160), .SCREEN_H(120), .CLEAR_EN(1'b1), .BG_COLOUR(3'b000)) u_dut1 (
      .clock(clock), .reset(reset), .start(start1),
      .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour_in(colour_in),
      .x(x1), .y(y1), .colour(c1), .plot(plot1), .busy(busy1), .done(done1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int pack(input int c, input int px, input int py);
      return (c << 16) | (px << 8) | py;
   endfunction

   // Reference: expected on-screen pixel stream and iteration count of the circle.
   function automatic int model(input int cx, input int cy, input int r, input int col, input bit clr);
      int ox = r;
      int oy = 0;
      int crit = 1 - r;
      int n = 0;
      int px[8];
      int py[8];
      exp_q.delete();
      if (clr)
         for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
               exp_q.push_back(pack(0, xx, yy));
      do begin
         px = '{cx + ox, cx + oy, cx - ox, cx - oy, cx - ox, cx - oy, cx + ox, cx + oy};
         py = '{cy + oy, cy + ox, cy + oy, cy + ox, cy - oy, cy - ox, cy - oy, cy - ox};
         for (int k = 0; k < 8; k++)
            if (px[k] >= 0 && px[k] < 160 && py[k] >= 0 && py[k] < 120)
               exp_q.push_back(pack(col, px[k], py[k]));
         n++;
         oy++;
         if (crit <= 0) crit += 2 * oy + 1;
         else begin
            ox--;
            crit += 2 * (oy - ox) + 1;
         end
      end while (oy <= ox);
      return n;
   endfunction

   task automatic run_circle(input bit sel, input int cx, input int cy, input int r,
                             input int col, input bit hold, input string tag);
      int n;
      int done_k = -1;
      int lim;
      n = model(cx, cy, r, col, sel);
      got_q.delete();
      @(negedge clock);
      centre_x  = 8'(cx);
      centre_y  = 7'(cy);
      radius    = 7'(r);
      colour_in = 3'(col);
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      for (int k = 0; k < 25000; k++) begin
         @(negedge clock);
         if (k == 0) begin
            centre_x  = 8'($urandom);
            centre_y  = 7'($urandom);
            radius    = 7'($urandom);
            colour_in = 3'($urandom);
            if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
         end
         if (sel ? plot1 : plot0)
            got_q.push_back(sel ? pack(int'(c1), int'(x1), int'(y1)) : pack(int'(c0), int'(x0), int'(y0)));
         if (sel ? done1 : done0) begin
            done_k = k;
            break;
         end
      end
      check({tag, " done latency"}, done_k, (sel ? 19200 : 0) + 1 + 9 * n);
      check({tag, " busy at done"}, sel ? busy1 : busy0, 1);
      check({tag, " plot at done"}, sel ? plot1 : plot0, 0);
      check({tag, " plot count"}, got_q.size(), exp_q.size());
      lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < lim; i++)
         check($sformatf("%s pixel %0d", tag, i), got_q[i], exp_q[i]);
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check({tag, " held done"}, sel ? done1 : done0, 1);
            check({tag, " held no plot"}, sel ? plot1 : plot0, 0);
         end
         start0 = 1'b0;
         start1 = 1'b0;
      end
      @(negedge clock);
      check({tag, " idle busy"}, sel ? busy1 : busy0, 0);
      check({tag, " idle done"}, sel ? done1 : done0, 0);
   endtask

   initial begin
      reset     = 1'b1;
      start0    = 1'b0;
      start1    = 1'b0;
      centre_x  = '0;
      centre_y  = '0;
      radius    = '0;
      colour_in = '0;
      @(negedge clock);
      check("reset x", x0, 0);
      check("reset y", y0, 0);
      check("reset colour", c0, 0);
      check("reset plot", plot0, 0);
      check("reset busy", busy0, 0);
      check("reset done", done0, 0);
      check("reset plot clr", plot1, 0);
      reset = 1'b0;

      run_circle(1'b0, 80, 60, 0, 3, 1'b0, "r0");
      run_circle(1'b0, 80, 60, 1, 6, 1'b0, "r1");
      run_circle(1'b0, 2, 2, 10, 7, 1'b0, "clip");
      run_circle(1'b0, 159, 119, 127, 1, 1'b0, "corner");
      run_circle(1'b1, 80, 60, 0, 4, 1'b0, "clear");

      // Reset while the fourth octant is pending.
      @(negedge clock);
      centre_x  = 8'd80;
      centre_y  = 7'd60;
      radius    = 7'd20;
      colour_in = 3'd5;
      start0    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         start0 = 1'b0;
      end
      check("pre-reset plot", plot0, 1);
      reset = 1'b1;
      #1;
      check("async reset plot", plot0, 0);
      check("async reset busy", busy0, 0);
      check("async reset done", done0, 0);
      check("async reset x", x0, 0);
      check("async reset y", y0, 0);
      @(negedge clock);
      reset = 1'b0;
      run_circle(1'b0, 80, 60, 20, 5, 1'b0, "after reset");

      run_circle(1'b0, 40, 30, 12, 2, 1'b1, "hold");

      for (int i = 0; i < 6; i++)
         run_circle(1'b0, $urandom_range(0, 159), $urandom_range(0, 119),
                    $urandom_range(0, 127), $urandom_range(0, 7), 1'b0, "random");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
